// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parameterised counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

    // Ceiling log2; used to size the prescaler phase register.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE; step is high on the enabled cycle that completes a period.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step
);

    localparam int unsigned PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_d;

    // Step decode is combinational so the count advances on the same edge the period completes.
    assign step = en && !restart && (phase == LAST);

    always_comb begin
        phase_d = phase;
        if (restart) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else begin
            phase <= phase_d;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Up/down modulo counter with prescaler, load/clear, wrap or saturate, terminal-count pulse and sticky overflow.
module param_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MOD_VALUE = 256,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD_VALUE - 1);
    localparam bit               SAT = (SATURATE != 0);

    // Reject illegal configurations at elaboration.
    generate
        if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
            $error("param_counter: WIDTH must be 1..31");
        end
        if (MOD_VALUE < 2 || 64'(MOD_VALUE) > (64'(1) << WIDTH)) begin : g_bad_mod
            $error("param_counter: MOD_VALUE must be 2..2**WIDTH");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("param_counter: PRESCALE must be 1..65535");
        end
        if (SATURATE > 1) begin : g_bad_sat
            $error("param_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    logic             restart;
    logic             step;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             ovf_d;

    assign restart = clear | load;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (restart),
        .step    (step)
    );

    // Next count and terminal detection; clear beats load beats step.
    always_comb begin
        count_d = count;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (32'(load_val) >= MOD_VALUE) ? TOP : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (count == TOP) begin
                    tc_d    = 1'b1;
                    count_d = (SAT == MODE_SAT) ? count : '0;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SAT == MODE_SAT) ? count : TOP;
                end else begin
                    count_d = count - WIDTH'(1);
                end
            end
        end
        // A new terminal event outranks a simultaneous clear request.
        ovf_d = tc_d | (ovf & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            ovf   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Directed and random checks of param_counter in wrap, saturate and prescale-by-3 configurations.
module tb_param_counter;

    localparam int MODV = 10;
    localparam int N    = 3;
    localparam int PRE [N] = '{1, 1, 3};
    localparam int SATM[N] = '{0, 1, 0};

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       ovf_clr;

    logic [3:0] d_count [N];
    logic       d_tc    [N];
    logic       d_ovf   [N];

    int m_cnt [N];
    int m_pre [N];
    bit m_tc  [N];
    bit m_ovf [N];

    int n_cmp;
    int n_fail;

    param_counter #(.WIDTH(4), .MOD_VALUE(10), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(d_count[0]), .tc(d_tc[0]), .ovf(d_ovf[0]));

    param_counter #(.WIDTH(4), .MOD_VALUE(10), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(d_count[1]), .tc(d_tc[1]), .ovf(d_ovf[1]));

    param_counter #(.WIDTH(4), .MOD_VALUE(10), .PRESCALE(3), .SATURATE(0)) u_pre3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(d_count[2]), .tc(d_tc[2]), .ovf(d_ovf[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // Reference behaviour: clear > load > prescaled step, modulo arithmetic on plain integers.
    task automatic model_clk();
        bit set;
        int term;
        for (int i = 0; i < N; i++) begin
            set = 1'b0;
            if (reset) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
                m_tc[i]  = 1'b0;
                m_ovf[i] = 1'b0;
                continue;
            end
            if (clear) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) >= MODV) ? MODV - 1 : int'(load_val);
                m_pre[i] = 0;
            end else if (en) begin
                if (m_pre[i] == PRE[i] - 1) begin
                    m_pre[i] = 0;
                    term = up_dn ? MODV - 1 : 0;
                    set  = (m_cnt[i] == term);
                    if (!(set && SATM[i] == 1))
                        m_cnt[i] = up_dn ? (m_cnt[i] + 1) % MODV : (m_cnt[i] + MODV - 1) % MODV;
                end else begin
                    m_pre[i] = m_pre[i] + 1;
                end
            end
            m_tc[i]  = set;
            m_ovf[i] = set || (m_ovf[i] && !ovf_clr);
        end
    endtask

    task automatic check_all(input string ctx);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.count[%0d]", ctx, i), int'(d_count[i]), m_cnt[i]);
            check($sformatf("%s.tc[%0d]", ctx, i), int'(d_tc[i]), int'(m_tc[i]));
            check($sformatf("%s.ovf[%0d]", ctx, i), int'(d_ovf[i]), int'(m_ovf[i]));
        end
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        model_clk();
        #1;
        check_all(ctx);
    endtask

    task automatic set_in(input logic e, input logic u, input logic c, input logic l,
                          input logic [3:0] lv, input logic oc);
        en = e; up_dn = u; clear = c; load = l; load_val = lv; ovf_clr = oc;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        tick("reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // Wrap up through the modulus.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick("wrap_up");
            check($sformatf("wrap_up.c%0d", k), int'(d_count[0]), k % 10);
            check($sformatf("wrap_up.tc%0d", k), int'(d_tc[0]), (k == 10) ? 1 : 0);
            check($sformatf("wrap_up.ovf%0d", k), int'(d_ovf[0]), (k >= 10) ? 1 : 0);
        end

        // Saturate down: load 1 then three down steps.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
        tick("sat_load");
        check("sat_load.count", int'(d_count[1]), 1);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick("sat_down");
            check($sformatf("sat_down.c%0d", k), int'(d_count[1]), 0);
            check($sformatf("sat_down.tc%0d", k), int'(d_tc[1]), (k >= 2) ? 1 : 0);
        end
        check("sat_down.ovf", int'(d_ovf[1]), 1);

        // Load clamp, then clear beats load.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
        tick("clamp");
        check("clamp.count", int'(d_count[0]), 9);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
        tick("clear_prio");
        check("clear_prio.count", int'(d_count[0]), 0);
        check("clear_prio.tc", int'(d_tc[0]), 0);

        // Prescale by 3: nine enabled cycles, a pause, one more enabled cycle.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 9; k++) tick("pre_run");
        check("pre_run.count", int'(d_count[2]), 3);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 5; k++) tick("pre_hold");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("pre_one");
        check("pre_one.count", int'(d_count[2]), 3);

        // Overflow set beats a coincident clear.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        tick("ovf_clear");
        check("ovf_clear.ovf", int'(d_ovf[0]), 0);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
        tick("race_load");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        tick("race_wrap");
        check("race_wrap.count", int'(d_count[0]), 0);
        check("race_wrap.ovf", int'(d_ovf[0]), 1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        tick("race_clr");
        check("race_clr.ovf", int'(d_ovf[0]), 0);

        // Asynchronous reset between edges with count=7, ovf=1.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
        tick("ar_load9");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick("ar_wrap");
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        tick("ar_load7");
        check("ar_pre.count", int'(d_count[0]), 7);
        check("ar_pre.ovf", int'(d_ovf[0]), 1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        #2;
        check("async.count", int'(d_count[0]), 0);
        check("async.ovf", int'(d_ovf[0]), 0);
        check("async.tc", int'(d_tc[0]), 0);
        model_reset();
        check_all("async");
        #1;
        reset = 1'b0;

        // First prescaled step lands PRESCALE enabled cycles after release.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick("post_reset");
            check($sformatf("post_reset.c%0d", k), int'(d_count[2]), (k == 3) ? 1 : 0);
        end

        // Random traffic including occasional resets.
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom % 4) != 0;
            up_dn    = $urandom % 2;
            clear    = ($urandom % 20) == 0;
            load     = ($urandom % 12) == 0;
            load_val = 4'($urandom);
            ovf_clr  = ($urandom % 8) == 0;
            reset    = ($urandom % 90) == 0;
            tick("random");
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
